// File: rtl/bcd_display_scan_ctrl.sv
// bcd_display_scan_ctrl: time-multiplexed 7-segment scan controller with a shared BCD decoder,
// blanking gaps between digits and frame-boundary commit of new display values.
module bcd_display_scan_ctrl #(
   parameter int NUM_DIGITS    = 4,
   parameter int DWELL_CYCLES  = 50000,
   parameter int DEAD_CYCLES   = 16,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          lz_blank,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic [4*NUM_DIGITS-1:0]       load_data,
   output logic [3:0]                    bcd_sel,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2((DWELL_CYCLES > DEAD_CYCLES ? DWELL_CYCLES : DEAD_CYCLES) + 1);
   localparam logic [NUM_DIGITS-1:0] OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
   state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [4*NUM_DIGITS-1:0] active, active_n, shadow;
   logic pending, pending_n, sup, sup_n, xfer, commit, last, nz, fd_n;
   assign load_ready = !pending;
   assign digit_idx  = idx;
   assign xfer       = load_valid && !pending;
   assign last       = idx == IW'(NUM_DIGITS - 1);
   // nz: some digit at or above the current one is non-zero, so it is not a leading zero
   always_comb begin
      nz = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (k >= int'(idx) && active[4*k +: 4] != 4'd0) nz = 1'b1;
   end
   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      sup_n   = sup;
      commit  = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         idx_n   = '0;
         cnt_n   = '0;
      end else if (state == IDLE) begin
         state_n = BLANK;
         idx_n   = '0;
         cnt_n   = '0;
         commit  = pending;
      end else if (state == BLANK) begin
         if (cnt == CW'(DEAD_CYCLES - 1)) begin
            state_n = DRIVE;
            cnt_n   = '0;
            sup_n   = lz_blank && idx != '0 && !nz;
         end else cnt_n = cnt + 1'b1;
      end else begin
         if (cnt == CW'(DWELL_CYCLES - 1)) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = last ? '0 : idx + 1'b1;
            commit  = last && pending;
         end else cnt_n = cnt + 1'b1;
      end
      active_n  = commit ? shadow : active;
      pending_n = xfer ? 1'b1 : commit ? 1'b0 : pending;
      fd_n      = state_n == DRIVE && idx_n == IW'(NUM_DIGITS - 1) && cnt_n == CW'(DWELL_CYCLES - 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         sup        <= 1'b0;
         an         <= OFF;
         bcd_sel    <= 4'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         active     <= active_n;
         shadow     <= xfer ? load_data : shadow;
         pending    <= pending_n;
         sup        <= sup_n;
         an         <= (state_n == DRIVE && !sup_n) ? OFF ^ (NUM_DIGITS'(1) << idx_n) : OFF;
         bcd_sel    <= state_n == IDLE ? 4'd0 : active_n[4*int'(idx_n) +: 4];
         frame_done <= fd_n;
      end
   end
endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// tb_bcd_display_scan_ctrl: scoreboard bench; stimulus queues expected frames, a monitor
// checks the 24-cycle trace preceding every frame_done.
module tb_bcd_display_scan_ctrl;
   logic clk = 0, rst = 1, enable = 0, lz_blank = 0, load_valid = 0;
   logic [15:0] load_data = '0;
   logic load_ready, frame_done;
   logic [3:0] bcd_sel, an;
   logic [1:0] digit_idx;
   typedef struct packed {logic [15:0] digits; logic [3:0] lit;} frame_t;
   frame_t exp_q[$];
   int checks = 0, errors = 0;
   logic [9:0] trace [24];

   bcd_display_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .DEAD_CYCLES(2), .AN_ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .lz_blank(lz_blank), .load_valid(load_valid),
      .load_ready(load_ready), .load_data(load_data), .bcd_sel(bcd_sel), .an(an),
      .digit_idx(digit_idx), .frame_done(frame_done));

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(logic [15:0] d);
      load_data  = d;
      load_valid = 1;
      tick(1);
      load_valid = 0;
   endtask

   task automatic wait_frames(int n);
      int seen = 0, t = 0;
      while (seen < n && t < 100 * n) begin
         @(negedge clk);
         t++;
         if (frame_done) seen++;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL wait_frames: saw %0d frames expected %0d", seen, n);
      end
   endtask

   // a frame is 4 digits x (2 blank + 4 drive) cycles; blank cycles and suppressed digits keep an=F
   always @(negedge clk) begin
      frame_t f;
      logic [239:0] act_t, exp_t;
      logic [3:0] a;
      for (int i = 0; i < 23; i++) trace[i] = trace[i+1];
      trace[23] = {an, bcd_sel, digit_idx};
      if (frame_done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame: got unexpected frame_done expected none");
         end else begin
            f = exp_q.pop_front();
            for (int k = 0; k < 4; k++)
               for (int j = 0; j < 6; j++) begin
                  a = (j < 2 || !f.lit[k]) ? 4'hF : ~(4'b0001 << k);
                  exp_t[239-10*(6*k+j) -: 10] = {a, f.digits[4*k +: 4], 2'(k)};
                  act_t[239-10*(6*k+j) -: 10] = trace[6*k+j];
               end
            if (act_t !== exp_t) begin
               errors++;
               $display("FAIL frame %h: got %h expected %h", f.digits, act_t, exp_t);
            end
         end
      end
   end

   initial begin
      tick(3);
      @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_bcd", bcd_sel, 0);
      chk("rst_idx", digit_idx, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ready", load_ready, 1);
      tick(1);
      rst = 0;
      load(16'h1234);
      @(negedge clk);
      chk("pend_idle", load_ready, 0);
      exp_q.push_back('{16'h1234, 4'hF});
      exp_q.push_back('{16'h1234, 4'hF});
      enable = 1;
      @(negedge clk);
      chk("commit_idle", load_ready, 1);
      wait_frames(2);
      exp_q.push_back('{16'h1234, 4'hF});
      exp_q.push_back('{16'h5678, 4'hF});
      exp_q.push_back('{16'h5678, 4'hF});
      tick(5);
      load(16'h5678);
      @(negedge clk);
      chk("pend_mid", load_ready, 0);
      load_data  = 16'h9999;
      load_valid = 1;
      tick(3);
      load_valid = 0;
      wait_frames(1);
      chk("pend_boundary", load_ready, 0);
      @(negedge clk);
      chk("ready_after_commit", load_ready, 1);
      wait_frames(2);
      lz_blank = 1;
      exp_q.push_back('{16'h5678, 4'hF});
      exp_q.push_back('{16'h0070, 4'h3});
      tick(1);
      load(16'h0070);
      wait_frames(1);
      exp_q.push_back('{16'h0000, 4'h1});
      tick(1);
      load(16'h0000);
      wait_frames(2);
      lz_blank = 0;
      exp_q.push_back('{16'h0000, 4'hF});
      tick(1);
      load(16'h4321);
      wait_frames(1);
      tick(16);
      @(negedge clk);
      chk("drive2_an", an, 4'b1011);
      chk("drive2_bcd", bcd_sel, 4'd3);
      enable = 0;
      @(negedge clk);
      chk("en_off_an", an, 4'hF);
      chk("en_off_idx", digit_idx, 0);
      tick(2);
      enable = 1;
      exp_q.push_back('{16'h4321, 4'hF});
      @(negedge clk);
      chk("reen_idle", an, 4'hF);
      @(negedge clk);
      chk("reen_blank0", an, 4'hF);
      @(negedge clk);
      chk("reen_blank1", an, 4'hF);
      @(negedge clk);
      chk("reen_lit_an", an, 4'hE);
      chk("reen_lit_bcd", bcd_sel, 4'd1);
      wait_frames(1);
      tick(1);
      load(16'h5555);
      tick(2);
      rst = 1;
      exp_q.push_back('{16'h0000, 4'hF});
      tick(1);
      rst = 0;
      @(negedge clk);
      chk("mid_rst_an", an, 4'hF);
      chk("mid_rst_bcd", bcd_sel, 0);
      chk("mid_rst_idx", digit_idx, 0);
      chk("mid_rst_fd", frame_done, 0);
      chk("mid_rst_ready", load_ready, 1);
      wait_frames(1);
      exp_q.push_back('{16'h0000, 4'hF});
      exp_q.push_back('{16'h9ABF, 4'hF});
      tick(1);
      load(16'h9ABF);
      wait_frames(2);
      tick(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
